// File: rtl/ifu_fetch.sv
// -----------------------------------------------------------------------------
// ifu_fetch -- instruction fetch stage feeding decode.
//
// Keeps the PC, issues one outstanding request at a time to instruction memory
// (req/gnt/rvalid), and hands each fetched instruction plus its address to
// decode over a valid/ready interface. The output register is backed by a
// one-entry skid register. A redirect flushes both and discards any response
// still in flight.
//
// Optional build macro: FETCH_PERF_EN adds the perf_fetch_cnt_o /
// perf_stall_cnt_o counter outputs.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   imem_req_o       fetch request (combinational)
//   imem_addr_o      fetch address, always the current PC
//   imem_gnt_i       memory accepts the request this cycle
//   imem_rvalid_i    read data valid
//   imem_rdata_i     fetched instruction
//   redirect_i       flush and restart fetch at redirect_pc_i
//   redirect_pc_i    new PC (low two bits ignored)
//   id_ready_i       decode consumes inst_o this cycle
//   inst_valid_o     inst_o / inst_addr_o valid
//   inst_o           instruction to decode (NOP_INST when invalid)
//   inst_addr_o      address of inst_o (0 when invalid)
//   perf_fetch_cnt_o instructions accepted by decode   (FETCH_PERF_EN only)
//   perf_stall_cnt_o cycles valid but not accepted      (FETCH_PERF_EN only)
// -----------------------------------------------------------------------------
module ifu_fetch #(
    parameter int                ADDR_W   = 64,
    parameter int                INST_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = 64'h0000_0000_8000_0000,
    parameter logic [INST_W-1:0] NOP_INST = 32'h0000_0013
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    input  logic              imem_gnt_i,
    input  logic              imem_rvalid_i,
    input  logic [INST_W-1:0] imem_rdata_i,
    input  logic              redirect_i,
    input  logic [ADDR_W-1:0] redirect_pc_i,
    input  logic              id_ready_i,
    output logic              inst_valid_o,
    output logic [INST_W-1:0] inst_o,
    output logic [ADDR_W-1:0] inst_addr_o
`ifdef FETCH_PERF_EN
    ,
    output logic [63:0]       perf_fetch_cnt_o,
    output logic [63:0]       perf_stall_cnt_o
`endif
);

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2,
        ST_DROP = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_pend_pc;

    logic              r_out_vld;
    logic [INST_W-1:0] r_out_inst;
    logic [ADDR_W-1:0] r_out_addr;

    logic              r_skid_vld;
    logic [INST_W-1:0] r_skid_inst;
    logic [ADDR_W-1:0] r_skid_addr;

    logic              w_req;
    logic              w_issue;
    logic              w_load_out;
    logic              w_load_skid;
    logic              w_skid_pop;
    logic [ADDR_W-1:0] w_redirect_pc;
    logic              w_unused;

    assign w_redirect_pc = {redirect_pc_i[ADDR_W-1:2], 2'b00};
    assign w_unused      = ^redirect_pc_i[1:0];

    // Next-state and datapath control
    always_comb begin
        w_state_nxt = r_state;
        w_load_out  = 1'b0;
        w_load_skid = 1'b0;
        w_skid_pop  = 1'b0;
        // Request only when there is somewhere to put the answer: skid empty
        // and the output register either empty or being drained this cycle.
        w_req       = rst_n && !redirect_i && (r_state == ST_REQ) &&
                      !r_skid_vld && (!r_out_vld || id_ready_i);
        w_issue     = w_req && imem_gnt_i;

        case (r_state)
            ST_REQ: begin
                // The request is held low during a redirect, so no grant can
                // be taken then and the FSM simply stays in REQ.
                if (w_issue) begin
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (imem_rvalid_i) begin
                    w_state_nxt = ST_REQ;
                    if (!redirect_i) begin
                        if (!r_out_vld || id_ready_i) begin
                            w_load_out = 1'b1;
                        end else begin
                            w_load_skid = 1'b1;
                            w_state_nxt = ST_HOLD;
                        end
                    end
                end else if (redirect_i) begin
                    // Response still owed by memory; swallow it later.
                    w_state_nxt = ST_DROP;
                end
            end
            ST_HOLD: begin
                if (redirect_i) begin
                    w_state_nxt = ST_REQ;
                end else if (id_ready_i) begin
                    w_skid_pop  = 1'b1;
                    w_state_nxt = ST_REQ;
                end
            end
            ST_DROP: begin
                if (imem_rvalid_i) begin
                    w_state_nxt = ST_REQ;
                end
            end
            default: w_state_nxt = ST_REQ;
        endcase
    end

    // Control state: FSM, PC and valid flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_REQ;
            r_pc       <= RESET_PC;
            r_out_vld  <= 1'b0;
            r_skid_vld <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (redirect_i) begin
                r_pc       <= w_redirect_pc;
                r_out_vld  <= 1'b0;
                r_skid_vld <= 1'b0;
            end else begin
                if (w_issue) begin
                    r_pc <= r_pc + ADDR_W'(4);
                end
                if (w_load_out || w_skid_pop) begin
                    r_out_vld <= 1'b1;
                end else if (id_ready_i) begin
                    r_out_vld <= 1'b0;
                end
                if (w_load_skid) begin
                    r_skid_vld <= 1'b1;
                end else if (w_skid_pop) begin
                    r_skid_vld <= 1'b0;
                end
            end
        end
    end

    // Payload registers; qualified by the valid flags, so no reset needed
    always_ff @(posedge clk) begin
        if (w_issue) begin
            r_pend_pc <= r_pc;
        end
        if (w_load_out) begin
            r_out_inst <= imem_rdata_i;
            r_out_addr <= r_pend_pc;
        end else if (w_skid_pop) begin
            r_out_inst <= r_skid_inst;
            r_out_addr <= r_skid_addr;
        end
        if (w_load_skid) begin
            r_skid_inst <= imem_rdata_i;
            r_skid_addr <= r_pend_pc;
        end
    end

    assign imem_req_o   = w_req;
    assign imem_addr_o  = r_pc;
    assign inst_valid_o = r_out_vld;
    assign inst_o       = r_out_vld ? r_out_inst : NOP_INST;
    assign inst_addr_o  = r_out_vld ? r_out_addr : '0;

`ifdef FETCH_PERF_EN
    logic [63:0] r_fetch_cnt;
    logic [63:0] r_stall_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_cnt <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (r_out_vld && id_ready_i) begin
                r_fetch_cnt <= r_fetch_cnt + 64'd1;
            end
            if (r_out_vld && !id_ready_i) begin
                r_stall_cnt <= r_stall_cnt + 64'd1;
            end
        end
    end

    assign perf_fetch_cnt_o = r_fetch_cnt;
    assign perf_stall_cnt_o = r_stall_cnt;
`endif

endmodule
